msk_share_encoder: RTL

//   Upstream masking stage: converts an unmasked count-bit word into a d-share Boolean

---
 rtl/msk_share_encoder.sv | 94 +++++++++
 1 files changed

// File: rtl/msk_share_encoder.sv
// Purpose: split an unmasked word into a d-share Boolean sharing using fresh PRNG randomness.
// Latency: 1 cycle from accept to out_valid when the buffer is empty; 2-entry output FIFO.
// Backpressure: input and randomness are accepted together only while the buffer is not full.
module msk_share_encoder #(
  parameter int d     = 2,
  parameter int count = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [count-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [count*(d-1)-1:0]   rnd_data,
  input  logic                     rnd_valid,
  output logic                     rnd_ready,
  output logic [count*d-1:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int W = count * d;

  generate
    if (d < 2) begin : g_bad_d
      $error("msk_share_encoder: d must be at least 2");
    end
  endgenerate

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic [1:0]   cnt;
  logic         full;
  logic         push;
  logic         pop;
  logic [W-1:0] enc;

  assign full      = (cnt == 2'd2);
  assign out_valid = (cnt != 2'd0);
  // Empty entries are always zero, so the head slot reads 0 whenever the buffer is empty.
  assign out_data  = mem[rptr];

  // Word and randomness form a join: each side is ready only when the other is offered.
  assign in_ready  = !full && rnd_valid && !flush && !rst;
  assign rnd_ready = !full && in_valid  && !flush && !rst;
  assign push      = in_valid && rnd_valid && !full && !flush;
  assign pop       = out_valid && out_ready;

  // Encode each bit: shares 1..d-1 are the masks, share 0 absorbs the data and all masks.
  always_comb begin
    enc = '0;
    for (int i = 0; i < count; i++) begin
      enc[i*d] = in_data[i];
      for (int k = 0; k < d-1; k++) begin
        enc[i*d+k+1] = rnd_data[i*(d-1)+k];
        enc[i*d]     = enc[i*d] ^ rnd_data[i*(d-1)+k];
      end
    end
  end

  // FIFO state: storage, pointers and occupancy; popped slots are zeroized.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      cnt    <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (pop) begin
        mem[rptr] <= '0;
        rptr      <= ~rptr;
      end
      // Placed after the zeroize so a same-edge refill of the popped slot wins.
      if (push) begin
        mem[wptr] <= enc;
        wptr      <= ~wptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
